// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle potentiometer emulator.
//   paddle_mode_e : how paddle positions are sourced (digital buttons or one stick axis)
//   POS_MAX       : largest legal paddle position
//   sat_step      : next position after one frame of button integration, clamped to 0..POS_MAX
//   axis_to_cap   : maps a signed stick axis (-128..127) onto a countdown of 0..255 scanlines
package paddle_pkg;

    // The encoding 2'd3 is not named and behaves like MODE_ANALOG_Y.
    typedef enum logic [1:0] {
        MODE_DIGITAL  = 2'd0,
        MODE_ANALOG_Y = 2'd1,
        MODE_ANALOG_X = 2'd2
    } paddle_mode_e;

    localparam logic [8:0] POS_MAX = 9'd255;

    // Positions are carried at 9 bits so that pos + step cannot wrap before the clamp.
    function automatic logic [8:0] sat_step(
        input logic [8:0] pos,
        input logic [8:0] step,
        input logic       up,
        input logic       down
    );
        logic [8:0] sum;
        sum      = pos + step;
        sat_step = pos;
        if (up && !down) begin
            sat_step = (pos < step) ? 9'd0 : pos - step;
        end else if (down && !up) begin
            sat_step = (sum > POS_MAX) ? POS_MAX : sum;
        end
    endfunction

    // Flipping the sign bit turns two's complement into offset binary.
    function automatic logic [8:0] axis_to_cap(input logic [7:0] axis);
        axis_to_cap = {1'b0, ~axis[7], axis[6:0]};
    endfunction

endpackage

// File: rtl/paddle_channel.sv
// One emulated paddle pot: a position register and a scanline countdown.
//   clk_sys  : system clock
//   reset    : synchronous, active-high
//   vs_rise  : one-cycle frame strobe from the parent; loads the countdown
//   hs_rise  : one-cycle scanline strobe from the parent; decrements the countdown
//   digital  : 1 when positions come from buttons, 0 when from the stick axis
//   step     : per-frame button step, chosen by the parent
//   up, down : level-sensitive buttons
//   axis     : signed stick axis already selected by the parent
//   pin      : pot input to the chip, high once the countdown has run out
//   position : current digital-mode position
module paddle_channel
    import paddle_pkg::*;
#(
    parameter logic [7:0] POS_INIT = 8'd128
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       vs_rise,
    input  logic       hs_rise,
    input  logic       digital,
    input  logic [8:0] step,
    input  logic       up,
    input  logic       down,
    input  logic [7:0] axis,
    output logic       pin,
    output logic [7:0] position
);

    logic [8:0] pos;
    logic [8:0] cap;

    // NOTE: state registers use non-blocking assignments so that cap <= pos below
    // takes the position from before this frame's update, giving the one-frame lag.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pos <= {1'b0, POS_INIT};
            cap <= '0;
        end else if (vs_rise) begin
            // A frame capture takes priority over a coincident scanline edge.
            if (digital) begin
                cap <= pos;
                pos <= sat_step(pos, step, up, down);
            end else begin
                // pos is held so digital mode resumes where it left off.
                cap <= axis_to_cap(axis);
            end
        end else if (hs_rise && (cap != 9'd0)) begin
            cap <= cap - 9'd1;
        end
    end

    assign pin      = (cap == 9'd0);
    assign position = pos[7:0];

endmodule

// File: rtl/paddle_pot_emu.sv
// Emulates the two RC paddle pots feeding the AY-3-8500 pinLPin/pinRPin inputs.
// Each frame a paddle position becomes a countdown in scanlines; the pot pin
// reads high once that countdown reaches zero.
//   clk_sys            : system clock
//   reset              : synchronous, active-high
//   hs, vs             : active-high syncs; rising edges mark scanlines / frames
//   speed              : selects STEP_FAST instead of STEP_SLOW for button integration
//   mode               : 0 digital, 1 analog Y, 2 analog X, 3 analog Y
//   p1_up .. p2_down   : level-sensitive paddle buttons
//   analog0, analog1   : stick axes for P1 / P2, [15:8]=Y and [7:0]=X, signed
//   lp_pin, rp_pin     : pot inputs to the chip
//   p1_pos, p2_pos     : current digital-mode positions
module paddle_pot_emu
    import paddle_pkg::*;
#(
    parameter int STEP_SLOW = 5,
    parameter int STEP_FAST = 8,
    parameter int POS_INIT  = 128
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic        speed,
    input  logic [1:0]  mode,
    input  logic        p1_up,
    input  logic        p1_down,
    input  logic        p2_up,
    input  logic        p2_down,
    input  logic [15:0] analog0,
    input  logic [15:0] analog1,
    output logic        lp_pin,
    output logic        rp_pin,
    output logic [7:0]  p1_pos,
    output logic [7:0]  p2_pos
);

    logic       vs_d;
    logic       hs_d;
    logic       vs_rise;
    logic       hs_rise;
    logic       digital;
    logic       use_x;
    logic [8:0] step;
    logic [7:0] axis_p1;
    logic [7:0] axis_p2;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vs_d <= 1'b0;
            hs_d <= 1'b0;
        end else begin
            vs_d <= vs;
            hs_d <= hs;
        end
    end

    assign vs_rise = vs & ~vs_d;
    assign hs_rise = hs & ~hs_d;

    // mode and speed feed the channels combinationally, but the channels only
    // act on them in a vs_rise cycle, so mid-frame changes are harmless.
    assign digital = (mode == MODE_DIGITAL);
    assign use_x   = (mode == MODE_ANALOG_X);
    assign step    = speed ? 9'(STEP_FAST) : 9'(STEP_SLOW);
    assign axis_p1 = use_x ? analog0[7:0] : analog0[15:8];
    assign axis_p2 = use_x ? analog1[7:0] : analog1[15:8];

    paddle_channel #(
        .POS_INIT (8'(POS_INIT))
    ) u_ch_p1 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .vs_rise  (vs_rise),
        .hs_rise  (hs_rise),
        .digital  (digital),
        .step     (step),
        .up       (p1_up),
        .down     (p1_down),
        .axis     (axis_p1),
        .pin      (lp_pin),
        .position (p1_pos)
    );

    paddle_channel #(
        .POS_INIT (8'(POS_INIT))
    ) u_ch_p2 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .vs_rise  (vs_rise),
        .hs_rise  (hs_rise),
        .digital  (digital),
        .step     (step),
        .up       (p2_up),
        .down     (p2_down),
        .axis     (axis_p2),
        .pin      (rp_pin),
        .position (p2_pos)
    );

endmodule

// File: tb/tb_paddle_pot_emu.sv
// Self-checking bench for paddle_pot_emu. The stimulus process pushes the
// expected countdown length and position for each channel at every frame;
// the monitor measures how many scanline edges each pin stays low after a
// frame edge and compares against the queued expectation.
module tb_paddle_pot_emu;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        hs      = 1'b0;
    logic        vs      = 1'b0;
    logic        speed   = 1'b0;
    logic [1:0]  mode    = 2'd0;
    logic        p1_up   = 1'b0;
    logic        p1_down = 1'b0;
    logic        p2_up   = 1'b0;
    logic        p2_down = 1'b0;
    logic [15:0] analog0 = 16'h0000;
    logic [15:0] analog1 = 16'h0000;
    logic        lp_pin;
    logic        rp_pin;
    logic [7:0]  p1_pos;
    logic [7:0]  p2_pos;

    always #5 clk_sys = ~clk_sys;

    paddle_pot_emu #(
        .STEP_SLOW (5),
        .STEP_FAST (8),
        .POS_INIT  (128)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .hs      (hs),
        .vs      (vs),
        .speed   (speed),
        .mode    (mode),
        .p1_up   (p1_up),
        .p1_down (p1_down),
        .p2_up   (p2_up),
        .p2_down (p2_down),
        .analog0 (analog0),
        .analog1 (analog1),
        .lp_pin  (lp_pin),
        .rp_pin  (rp_pin),
        .p1_pos  (p1_pos),
        .p2_pos  (p2_pos)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int cap;
        int pos;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    // Reference positions, kept in plain integers.
    int mpos1 = 128;
    int mpos2 = 128;

    function automatic int model_step(input int p, input int st, input logic up, input logic dn);
        if (up && !dn) return (p - st < 0) ? 0 : p - st;
        if (dn && !up) return (p + st > 255) ? 255 : p + st;
        return p;
    endfunction

    function automatic int axis_cap(input logic [15:0] a, input logic [1:0] m);
        logic [7:0] b;
        b = (m == 2'd2) ? a[7:0] : a[15:8];
        return int'($signed(b)) + 128;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    localparam int ACT_NONE  = 0;
    localparam int ACT_RESET = 1;
    localparam int ACT_MODE  = 2;

    // One frame: vs pulse (optionally with a coincident hs rise), then `lines`
    // hs pulses. An optional action is injected before scanline act_line.
    task automatic run_frame(input int lines, input bit coincide, input int act_line, input int act);
        exp_t e1;
        exp_t e2;
        int   st;
        st = speed ? 8 : 5;
        if (mode == 2'd0) begin
            e1.cap = mpos1;
            e2.cap = mpos2;
            mpos1  = model_step(mpos1, st, p1_up, p1_down);
            mpos2  = model_step(mpos2, st, p2_up, p2_down);
        end else begin
            e1.cap = axis_cap(analog0, mode);
            e2.cap = axis_cap(analog1, mode);
        end
        e1.pos = mpos1;
        e2.pos = mpos2;
        q1.push_back(e1);
        q2.push_back(e2);

        vs = 1'b1;
        hs = coincide;
        tick();
        vs = 1'b0;
        hs = 1'b0;
        tick();
        for (int i = 0; i < lines; i++) begin
            if (i == act_line && act == ACT_RESET) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                mpos1 = 128;
                mpos2 = 128;
                check("midreset_lp_pin", 32'(lp_pin), 32'd1);
                check("midreset_rp_pin", 32'(rp_pin), 32'd1);
                check("midreset_p1_pos", 32'(p1_pos), 32'd128);
                check("midreset_p2_pos", 32'(p2_pos), 32'd128);
            end
            if (i == act_line && act == ACT_MODE) begin
                mode    = 2'd1;
                analog0 = 16'h7F00;
            end
            hs = 1'b1;
            tick();
            hs = 1'b0;
            tick();
        end
    endtask

    // ---------------- monitor ----------------
    bit armed[2];
    int cnt[2];
    bit mon_prev_vs = 1'b0;
    bit mon_prev_hs = 1'b0;

    task automatic pop_expect(input int c, output bit ok, output exp_t e);
        ok = 1'b1;
        e  = '{cap: 0, pos: 0};
        if (c == 0) begin
            if (q1.size() == 0) ok = 1'b0;
            else e = q1.pop_front();
        end else begin
            if (q2.size() == 0) ok = 1'b0;
            else e = q2.pop_front();
        end
    endtask

    task automatic complete(input int c, input int count, input int pos_now);
        exp_t e;
        bit   ok;
        pop_expect(c, ok, e);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ch%0d_scoreboard: pin rose with no expectation queued", c + 1);
        end else begin
            check($sformatf("ch%0d_countdown_lines", c + 1), 32'(count), 32'(e.cap));
            check($sformatf("ch%0d_pos", c + 1), 32'(pos_now), 32'(e.pos));
        end
    endtask

    initial begin
        logic s_vs, s_hs, s_rst;
        bit   vr, hr;
        exp_t dropped;
        bit   ok;
        int   pins[2];
        int   poss[2];
        armed = '{1'b0, 1'b0};
        cnt   = '{0, 0};
        forever begin
            @(posedge clk_sys);
            s_vs  = vs;
            s_hs  = hs;
            s_rst = reset;
            #2;
            pins[0] = int'(lp_pin);
            pins[1] = int'(rp_pin);
            poss[0] = int'(p1_pos);
            poss[1] = int'(p2_pos);
            if (s_rst) begin
                mon_prev_vs = 1'b0;
                mon_prev_hs = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    if (armed[c]) pop_expect(c, ok, dropped);
                    armed[c] = 1'b0;
                end
            end else begin
                vr = s_vs && !mon_prev_vs;
                hr = s_hs && !mon_prev_hs;
                mon_prev_vs = s_vs;
                mon_prev_hs = s_hs;
                for (int c = 0; c < 2; c++) begin
                    if (vr) begin
                        if (armed[c]) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL ch%0d_timeout: pin still low at next frame after %0d lines", c + 1, cnt[c]);
                            pop_expect(c, ok, dropped);
                        end
                        armed[c] = 1'b1;
                        cnt[c]   = 0;
                    end else if (hr && armed[c]) begin
                        cnt[c]++;
                    end
                    if (armed[c] && pins[c] == 1) begin
                        complete(c, cnt[c], poss[c]);
                        armed[c] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Test 1: reset state and idle frames
        tick();
        tick();
        reset = 1'b0;
        check("reset_lp_pin", 32'(lp_pin), 32'd1);
        check("reset_rp_pin", 32'(rp_pin), 32'd1);
        check("reset_p1_pos", 32'(p1_pos), 32'd128);
        check("reset_p2_pos", 32'(p2_pos), 32'd128);
        tick();
        for (int f = 0; f < 3; f++) run_frame(262, 1'b0, -1, ACT_NONE);
        check("idle_p1_pos", 32'(p1_pos), 32'd128);

        // Test 2: slow up from 128 saturates at 0
        p1_up = 1'b1;
        run_frame(262, 1'b0, -1, ACT_NONE);
        check("up_first_step", 32'(p1_pos), 32'd123);
        for (int f = 1; f < 30; f++) run_frame(262, 1'b0, -1, ACT_NONE);
        p1_up = 1'b0;
        check("up_saturated", 32'(p1_pos), 32'd0);

        // Test 3: p2 down to 250, then fast step clamps at 255; both buttons hold
        p1_up   = 1'b1;
        p1_down = 1'b1;
        p2_down = 1'b1;
        speed   = 1'b1;
        for (int f = 0; f < 14; f++) run_frame(262, 1'b0, -1, ACT_NONE);
        speed = 1'b0;
        for (int f = 0; f < 2; f++) run_frame(262, 1'b0, -1, ACT_NONE);
        check("down_reach_250", 32'(p2_pos), 32'd250);
        speed = 1'b1;
        for (int f = 0; f < 2; f++) run_frame(262, 1'b0, -1, ACT_NONE);
        check("down_clamp_255", 32'(p2_pos), 32'd255);
        p2_up = 1'b1;
        for (int f = 0; f < 2; f++) run_frame(262, 1'b0, -1, ACT_NONE);
        check("both_hold_p2", 32'(p2_pos), 32'd255);
        check("both_hold_p1", 32'(p1_pos), 32'd0);
        p1_up   = 1'b0;
        p1_down = 1'b0;
        p2_up   = 1'b0;
        p2_down = 1'b0;

        // Test 4: analog modes; a held button must not move pos
        p1_up   = 1'b1;
        mode    = 2'd1;
        analog0 = 16'h0000;
        analog1 = 16'h8000;
        run_frame(262, 1'b0, -1, ACT_NONE);
        analog1 = 16'h7F00;
        run_frame(262, 1'b0, -1, ACT_NONE);
        mode    = 2'd2;
        analog0 = 16'h8000;
        analog1 = 16'h00C0;
        run_frame(262, 1'b0, -1, ACT_NONE);
        mode    = 2'd3;
        analog0 = 16'h1000;
        analog1 = 16'hFF00;
        run_frame(262, 1'b0, -1, ACT_NONE);
        p1_up = 1'b0;
        check("analog_p1_pos_held", 32'(p1_pos), 32'd0);
        check("analog_p2_pos_held", 32'(p2_pos), 32'd255);

        // Test 5: coincident vs/hs rise captures without decrement
        mode    = 2'd0;
        speed   = 1'b1;
        p1_down = 1'b1;
        run_frame(262, 1'b0, -1, ACT_NONE);
        p1_down = 1'b0;
        check("resume_digital_p1", 32'(p1_pos), 32'd8);
        run_frame(262, 1'b1, -1, ACT_NONE);

        // Test 6: reset mid-countdown, then a mid-frame mode change
        mode    = 2'd1;
        analog0 = 16'hBC00;
        analog1 = 16'h4000;
        run_frame(262, 1'b0, 10, ACT_RESET);
        check("post_reset_lp_high", 32'(lp_pin), 32'd1);
        check("post_reset_rp_high", 32'(rp_pin), 32'd1);
        mode = 2'd0;
        run_frame(262, 1'b0, 20, ACT_MODE);
        run_frame(262, 1'b0, -1, ACT_NONE);

        for (int i = 0; i < 4; i++) tick();
        check("sb_p1_drained", 32'(q1.size()), 32'd0);
        check("sb_p2_drained", 32'(q2.size()), 32'd0);
        check("p1_meas_closed", 32'(armed[0]), 32'd0);
        check("p2_meas_closed", 32'(armed[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
